// File: rtl/audio_serial_pkg.sv
// Shared definitions for the framed audio serial receive path:
// FSM state encoding, default frame geometry and the frame-width helper.
package audio_serial_pkg;

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH    = 24;
    localparam int DEF_CHANNELS = 2;

    function automatic int frame_w(input int channels, input int width);
        return channels * width;
    endfunction

endpackage

// File: rtl/sipo_word_shifter.sv
// WIDTH-bit serial word shifter with bit-order select. load_first restarts the
// word from the current bit; word_done flags the bit that completes a word.
module sipo_word_shifter
    import audio_serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shift_en,
    input  logic             load_first,
    input  logic             last_bit,
    input  logic             sdata,
    output logic [WIDTH-1:0] word_next,
    output logic             word_done
);

    logic [WIDTH-1:0] word_r;
    logic [WIDTH-1:0] base_s;

    // Next word value: shift the new bit into either the current word or a cleared one
    always_comb begin
        base_s    = {WIDTH{1'b0}};
        word_next = {WIDTH{1'b0}};
        if (load_first) begin
            base_s = {WIDTH{1'b0}};
        end else begin
            base_s = word_r;
        end
        if (MSB_FIRST) begin
            word_next = {base_s[WIDTH-2:0], sdata};
        end else begin
            word_next = {sdata, base_s[WIDTH-1:1]};
        end
        word_done = shift_en & ~load_first & last_bit;
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_r <= {WIDTH{1'b0}};
        end else if (shift_en) begin
            word_r <= word_next;
        end else begin
            word_r <= word_r;
        end
    end

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Framed serial-to-parallel deserializer with sync hunting, valid/ready output
// and sticky overflow. Define SIPO_FRAME_CNT_EN to add the frame_cnt output.
module sipo_frame_deserializer
    import audio_serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sdata,
    input  logic                      bit_en,
    input  logic                      sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic                      sync_err
`ifdef SIPO_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int FRAME_W = frame_w(CHANNELS, WIDTH);
    localparam int BW      = $clog2(WIDTH + 1);
    localparam int CW      = $clog2(CHANNELS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

    state_e               state_r, state_n;
    logic [BW-1:0]        bit_cnt_r, bit_cnt_n;
    logic [CW-1:0]        ch_cnt_r, ch_cnt_n;
    logic [FRAME_W-1:0]   frame_buf_r, frame_buf_n;
    logic [FRAME_W-1:0]   frame_next_s;
    logic [FRAME_W-1:0]   out_data_r, out_data_n;
    logic                 out_valid_r, out_valid_n;
    logic                 overflow_r, overflow_n;
    logic                 sync_err_r;
    logic                 err_s;
    logic                 complete_s;
    logic                 deliver_s;
    logic                 drop_s;
    logic                 boundary_s;
    logic                 sh_shift_s;
    logic                 sh_load_s;
    logic [WIDTH-1:0]     word_s;
    logic                 word_done_s;

    sipo_word_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk        (clk),
        .rstn       (rstn),
        .shift_en   (sh_shift_s | sh_load_s),
        .load_first (sh_load_s),
        .last_bit   (bit_cnt_r == BIT_LAST),
        .sdata      (sdata),
        .word_next  (word_s),
        .word_done  (word_done_s)
    );

    // Frame buffer with the word being finished dropped into its channel slot
    always_comb begin
        frame_next_s = frame_buf_r;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_cnt_r == CW'(k)) begin
                frame_next_s[k*WIDTH +: WIDTH] = word_s;
            end else begin
                frame_next_s[k*WIDTH +: WIDTH] = frame_buf_r[k*WIDTH +: WIDTH];
            end
        end
    end

    // Framing FSM: hunting, bit/channel counting, sync checking
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        ch_cnt_n    = ch_cnt_r;
        frame_buf_n = frame_buf_r;
        sh_shift_s  = 1'b0;
        sh_load_s   = 1'b0;
        err_s       = 1'b0;
        complete_s  = 1'b0;
        // Counters both at zero inside SHIFT only happen right after a completed frame
        boundary_s  = (bit_cnt_r == {BW{1'b0}}) && (ch_cnt_r == {CW{1'b0}});
        case (state_r)
            ST_HUNT: begin
                if (bit_en && sync) begin
                    sh_load_s = 1'b1;
                    bit_cnt_n = BW'(1);
                    ch_cnt_n  = {CW{1'b0}};
                    state_n   = ST_SHIFT;
                end else begin
                    state_n = ST_HUNT;
                end
            end
            ST_SHIFT: begin
                if (!bit_en) begin
                    state_n = ST_SHIFT;
                end else if (sync) begin
                    sh_load_s = 1'b1;
                    bit_cnt_n = BW'(1);
                    ch_cnt_n  = {CW{1'b0}};
                    err_s     = ~boundary_s;
                end else if (boundary_s) begin
                    err_s   = 1'b1;
                    state_n = ST_HUNT;
                end else begin
                    sh_shift_s = 1'b1;
                    if (word_done_s) begin
                        bit_cnt_n   = {BW{1'b0}};
                        frame_buf_n = frame_next_s;
                        if (ch_cnt_r == CH_LAST) begin
                            ch_cnt_n   = {CW{1'b0}};
                            complete_s = 1'b1;
                        end else begin
                            ch_cnt_n = ch_cnt_r + CW'(1);
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r + BW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    // Output handshake and overflow bookkeeping
    always_comb begin
        deliver_s   = complete_s & (~out_valid_r | out_ready);
        drop_s      = complete_s & out_valid_r & ~out_ready;
        out_data_n  = out_data_r;
        out_valid_n = out_valid_r;
        overflow_n  = overflow_r;
        if (deliver_s) begin
            out_data_n  = frame_next_s;
            out_valid_n = 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_n = 1'b0;
        end else begin
            out_valid_n = out_valid_r;
        end
        if (drop_s) begin
            overflow_n = 1'b1;
        end else if (ovf_clr) begin
            overflow_n = 1'b0;
        end else begin
            overflow_n = overflow_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_HUNT;
            bit_cnt_r   <= {BW{1'b0}};
            ch_cnt_r    <= {CW{1'b0}};
            frame_buf_r <= {FRAME_W{1'b0}};
            out_data_r  <= {FRAME_W{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            ch_cnt_r    <= ch_cnt_n;
            frame_buf_r <= frame_buf_n;
            out_data_r  <= out_data_n;
            out_valid_r <= out_valid_n;
            overflow_r  <= overflow_n;
            sync_err_r  <= err_s;
        end
    end

`ifdef SIPO_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Delivered-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_cnt_r <= 16'h0000;
        end else if (deliver_s) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign sync_err  = sync_err_r;

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed self-checking bench for sipo_frame_deserializer (WIDTH=8, CHANNELS=2),
// with a second MSB_FIRST=0 instance sharing the same serial stream.
module tb_sipo_frame_deserializer;

    logic        clk;
    logic        rstn;
    logic        sdata;
    logic        bit_en;
    logic        sync;
    logic        out_ready;
    logic        ovf_clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        overflow;
    logic        sync_err;
    logic [15:0] out_data_l;
    logic        out_valid_l;
    logic        overflow_l;
    logic        sync_err_l;
`ifdef SIPO_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt_l;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sipo_frame_deserializer #(.WIDTH(8), .CHANNELS(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rstn(rstn), .sdata(sdata), .bit_en(bit_en), .sync(sync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .sync_err(sync_err)
`ifdef SIPO_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    sipo_frame_deserializer #(.WIDTH(8), .CHANNELS(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn), .sdata(sdata), .bit_en(bit_en), .sync(sync),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .overflow(overflow_l), .ovf_clr(ovf_clr), .sync_err(sync_err_l)
`ifdef SIPO_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bit_en strobe; called and returns at a negedge
    task automatic send_bit(input logic b, input logic s);
        sdata  = b;
        sync   = s;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        sync   = 1'b0;
    endtask

    // Stream positions lo..hi of frame f: ch0 = f[7:0] first, then ch1, MSB-first
    task automatic send_range(input logic [15:0] f, input int lo, input int hi, input logic s0);
        logic [7:0] w;
        for (int i = lo; i <= hi; i++) begin
            w = (i < 8) ? f[7:0] : f[15:8];
            send_bit(w[7 - (i % 8)], s0 && (i == lo));
        end
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_range(f, 0, 15, 1'b1);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== 16'h0000) $display("FAIL rst_data: got %h exp 0000", out_data); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b exp 0", overflow); else pass_cnt++;
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL rst_syncerr: got %0b exp 0", sync_err); else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_range(16'h3CA5, 0, 14, 1'b1);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b exp 0", out_valid); else pass_cnt++;
        send_range(16'h3CA5, 15, 15, 1'b0);
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0b exp 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== 16'h3CA5) $display("FAIL basic_data: got %h exp 3ca5", out_data); else pass_cnt++;
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL basic_syncerr: got %0b exp 0", sync_err); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_pulse: got %0b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        send_frame(16'h8001);
        chk_cnt++; if (out_data !== 16'h8001) $display("FAIL msb_data: got %h exp 8001", out_data); else pass_cnt++;
        chk_cnt++; if (out_valid_l !== 1'b1) $display("FAIL lsb_valid: got %0b exp 1", out_valid_l); else pass_cnt++;
        chk_cnt++; if (out_data_l !== 16'h0180) $display("FAIL lsb_data: got %h exp 0180", out_data_l); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_frame(16'h1111);
        chk_cnt++; if (out_data !== 16'h1111) $display("FAIL ovf_first_data: got %h exp 1111", out_data); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_first_flag: got %0b exp 0", overflow); else pass_cnt++;
        send_frame(16'h2222);
        chk_cnt++; if (out_data !== 16'h1111) $display("FAIL ovf_kept_data: got %h exp 1111", out_data); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b exp 1", overflow); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b exp 1", overflow); else pass_cnt++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %0b exp 0", overflow); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf_drain: got %0b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_sync_err();
        send_range(16'hFFFF, 0, 4, 1'b1);
        send_range(16'hBEEF, 0, 0, 1'b1);
        chk_cnt++; if (sync_err !== 1'b1) $display("FAIL serr_pulse: got %0b exp 1", sync_err); else pass_cnt++;
        send_range(16'hBEEF, 1, 1, 1'b0);
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL serr_one_cycle: got %0b exp 0", sync_err); else pass_cnt++;
        send_range(16'hBEEF, 2, 15, 1'b0);
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL serr_valid: got %0b exp 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== 16'hBEEF) $display("FAIL serr_data: got %h exp beef", out_data); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_missing_sync();
        send_range(16'h0000, 0, 0, 1'b0);
        chk_cnt++; if (sync_err !== 1'b1) $display("FAIL miss_pulse: got %0b exp 1", sync_err); else pass_cnt++;
        send_range(16'hFFFF, 0, 3, 1'b0);
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL miss_hunt_quiet: got %0b exp 0", sync_err); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL miss_hunt_valid: got %0b exp 0", out_valid); else pass_cnt++;
        send_frame(16'h1234);
        chk_cnt++; if (out_data !== 16'h1234) $display("FAIL miss_resync_data: got %h exp 1234", out_data); else pass_cnt++;
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL miss_resync_err: got %0b exp 0", sync_err); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_range(16'h7777, 0, 6, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk_cnt++; if (out_data !== 16'h0000) $display("FAIL rmid_data: got %h exp 0000", out_data); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b exp 0", out_valid); else pass_cnt++;
        rstn = 1'b1;
        @(negedge clk);
        send_frame(16'h55AA);
        chk_cnt++; if (out_data !== 16'h55AA) $display("FAIL rmid_frame: got %h exp 55aa", out_data); else pass_cnt++;
        chk_cnt++; if (sync_err !== 1'b0) $display("FAIL rmid_syncerr: got %0b exp 0", sync_err); else pass_cnt++;
`ifdef SIPO_FRAME_CNT_EN
        chk_cnt++; if (frame_cnt !== 16'd1) $display("FAIL rmid_cnt: got %0d exp 1", frame_cnt); else pass_cnt++;
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_frame(16'hA1A1);
        send_range(16'hC3D4, 0, 14, 1'b1);
        out_ready = 1'b1;
        send_range(16'hC3D4, 15, 15, 1'b0);
        out_ready = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %0b exp 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== 16'hC3D4) $display("FAIL b2b_data: got %h exp c3d4", out_data); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL b2b_ovf: got %0b exp 0", overflow); else pass_cnt++;
`ifdef SIPO_FRAME_CNT_EN
        chk_cnt++; if (frame_cnt !== 16'd3) $display("FAIL b2b_cnt: got %0d exp 3", frame_cnt); else pass_cnt++;
`endif
        @(negedge clk);
        chk_cnt++; if (out_data !== 16'hC3D4) $display("FAIL b2b_hold: got %h exp c3d4", out_data); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %0b exp 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        rstn      = 1'b0;
        sdata     = 1'b0;
        bit_en    = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        test_reset();
        test_basic();
        test_lsb_first();
        test_overflow();
        test_sync_err();
        test_missing_sync();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
